fetch_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 84 ++++++++
 rtl/fetch_fifo_chk.sv | 10 +
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address/data widths, memory read latency, the
// default reset fetch address, the {pc, instr} entry carried from the memory
// return path to decode, and the sequential-pc helper.
package cpu_pkg;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int MEM_RD_LAT = 2;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // Next sequential word address; wraps 0xFFFF -> 0x0000 by width.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + 16'h0001;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small output FIFO of {pc, instr} entries. Entry 0 is the head and is a
// register that drives decode directly; on a pop the remaining entries shift
// down. The head keeps its old contents when the FIFO drains empty.
// Ports: clk, rst_n (async active-low), push/push_data (write), pop (read),
// flush (discard everything), out_valid/head (head entry), count (occupancy).
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       out_valid,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     entry_r [DEPTH];
  fetch_entry_t     entry_s [DEPTH];
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] wr_idx_s;
  logic             valid_r;
  logic             pop_ok_s;
  logic             push_ok_s;
  logic             full_s;

  assign head      = entry_r[0];
  assign count     = count_r;
  assign out_valid = valid_r;
  assign full_s    = (count_r == CNT_W'(DEPTH));

  // Next-state of the entry array and occupancy for push/pop/flush.
  always_comb begin
    entry_s   = entry_r;
    count_s   = count_r;
    pop_ok_s  = pop && (count_r != '0);
    // After a pop the shifted array has one fewer entry, so the write slot moves down.
    wr_idx_s  = count_r - CNT_W'(pop_ok_s);
    push_ok_s = push && (wr_idx_s < CNT_W'(DEPTH));
    if (flush) begin
      count_s = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok_s && (wr_idx_s == CNT_W'(i))) begin
          entry_s[i] = push_data;
        end else if (pop_ok_s && (i < DEPTH-1) && (CNT_W'(i+1) < count_r)) begin
          // Only occupied slots shift, so a lone head that is popped keeps its value.
          entry_s[i] = entry_r[(i+1) % DEPTH];
        end else begin
          entry_s[i] = entry_r[i];
        end
      end
      count_s = count_r - CNT_W'(pop_ok_s) + CNT_W'(push_ok_s);
    end
  end

  // Entry, occupancy and registered valid state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
      count_r <= '0;
      valid_r <= 1'b0;
    end else begin
      entry_r <= entry_s;
      count_r <= count_s;
      valid_r <= (count_s != '0);
    end
  end

  fetch_fifo_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .full  (full_s)
  );
endmodule

// File: rtl/fetch_fifo_chk.sv
// Checker for fetch_fifo: a push must never arrive while the FIFO is full.
// Ports: clk, rst_n, push (write strobe), full (FIFO holds DEPTH entries).
module fetch_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic full
);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end. Issues one read per cycle on memory port 0
// while credit allows, tracks the two in-flight reads (s1, s2) so returning
// data can be tagged with its pc, buffers returns in fetch_fifo and hands
// {pc, instr} to decode with valid/ready. A redirect flushes everything in
// flight and issues the target in the same cycle.
// Ports: clk, rst_n; mem_raddr/mem_req (read port), mem_rdata (2-cycle data);
// redirect_valid/redirect_pc; out_valid/out_ready/out_instr/out_pc (decode).
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                DEPTH    = MEM_RD_LAT + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int OCC_W = CNT_W + 2;

  logic [ADDR_W-1:0] pc_r;
  logic              s1_valid_r;
  logic [ADDR_W-1:0] s1_pc_r;
  logic              s2_valid_r;
  logic [ADDR_W-1:0] s2_pc_r;

  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_valid_s;
  fetch_entry_t      head_s;
  fetch_entry_t      push_entry_s;
  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic [OCC_W-1:0]  occ_s;

  assign pop_s        = fifo_valid_s & out_ready;
  // A return landing in the redirect cycle belongs to the cancelled stream.
  assign push_s       = s2_valid_r & ~redirect_valid;
  assign push_entry_s = '{pc: s2_pc_r, instr: mem_rdata};

  // Credit: everything buffered or in flight, minus what decode takes now.
  assign occ_s = OCC_W'(fifo_count_s) + OCC_W'(s1_valid_r) + OCC_W'(s2_valid_r) - OCC_W'(pop_s);

  // Issue decision and read address; nothing issues while reset is held.
  always_comb begin
    if (redirect_valid) begin
      mem_raddr = redirect_pc;
    end else begin
      mem_raddr = pc_r;
    end
    issue_s = rst_n & (redirect_valid | (occ_s < OCC_W'(DEPTH)));
    mem_req = issue_s;
  end

  // Fetch pc and the two-stage in-flight read tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      s1_valid_r <= 1'b0;
      s1_pc_r    <= '0;
      s2_valid_r <= 1'b0;
      s2_pc_r    <= '0;
    end else begin
      if (issue_s) begin
        pc_r <= pc_inc(mem_raddr);
      end else begin
        pc_r <= pc_r;
      end
      // On redirect issue_s is forced high and mem_raddr is the target.
      s1_valid_r <= issue_s;
      s1_pc_r    <= mem_raddr;
      s2_valid_r <= s1_valid_r & ~redirect_valid;
      s2_pc_r    <= s1_pc_r;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .out_valid (fifo_valid_s),
    .head      (head_s),
    .count     (fifo_count_s)
  );

  assign out_valid = fifo_valid_s;
  assign out_pc    = head_s.pc;
  assign out_instr = head_s.instr;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. The memory returns 0x1000+addr two
// cycles after the address. The reference model is the architectural stream:
// after reset or a redirect, decode must see consecutive pcs starting at the
// new base, each paired with 0x1000+pc. A monitor pops expected entries from
// a queue on every handshake.
module tb_fetch_stage;
  localparam logic [15:0] TB_RESET_PC = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem_raddr;
  logic [15:0] mem_rdata;
  logic        mem_req;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  fetch_stage #(.RESET_PC(TB_RESET_PC), .DEPTH(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (mem_rdata),
    .mem_req        (mem_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: fixed 2-cycle latency, contents 0x1000 + address.
  logic [15:0] a1;
  logic [15:0] a2;
  always @(posedge clk) begin
    a1 <= mem_raddr;
    a2 <= a1;
  end
  assign mem_rdata = 16'h1000 + a2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected pcs of the current stream.
  logic [15:0] exp_q[$];
  logic [15:0] next_pc;
  logic [15:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      next_pc = TB_RESET_PC;
    end else begin
      if (out_valid && out_ready) begin
        while (exp_q.size() < 4) begin
          exp_q.push_back(next_pc);
          next_pc = next_pc + 16'h0001;
        end
        e = exp_q.pop_front();
        n_pops++;
        check("pop_pc", {16'h0, out_pc}, {16'h0, e});
        check("pop_instr", {16'h0, out_instr}, {16'h0, 16'h1000 + e});
      end
      if (redirect_valid) begin
        check("redirect_raddr", {16'h0, mem_raddr}, {16'h0, redirect_pc});
        check("redirect_req", {31'h0, mem_req}, 32'h1);
        exp_q.delete();
        next_pc = redirect_pc;
      end
    end
  end

  // Release reset and check first-fetch latency: issue in C0, data in C3.
  task automatic release_and_first(input logic ready);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_req", {31'h0, mem_req}, 32'h1);
    check("first_raddr", {16'h0, mem_raddr}, {16'h0, TB_RESET_PC});
    check("lat_c0_valid", {31'h0, out_valid}, 32'h0);
    if (ready) begin
      @(negedge clk);
      check("lat_c1_valid", {31'h0, out_valid}, 32'h0);
      @(negedge clk);
      check("lat_c2_valid", {31'h0, out_valid}, 32'h0);
      @(negedge clk);
      check("lat_c3_valid", {31'h0, out_valid}, 32'h1);
      check("lat_c3_pc", {16'h0, out_pc}, {16'h0, TB_RESET_PC});
    end
  endtask

  // Redirect in the current cycle (caller is at posedge+1) and check the gap.
  task automatic redirect_and_check(input logic [15:0] target);
    logic [15:0] t1;
    logic [15:0] t2;
    t1 = target + 16'h0001;
    t2 = target + 16'h0002;
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    #3;
    check("redir_t1_valid", {31'h0, out_valid}, 32'h0);
    check("redir_t1_raddr", {16'h0, mem_raddr}, {16'h0, t1});
    @(posedge clk); #4;
    check("redir_t2_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #4;
    check("redir_t3_valid", {31'h0, out_valid}, 32'h1);
    check("redir_t3_pc", {16'h0, out_pc}, {16'h0, target});
    check("redir_t3_instr", {16'h0, out_instr}, {16'h0, 16'h1000 + target});
    @(posedge clk); #4;
    check("redir_t4_pc", {16'h0, out_pc}, {16'h0, t1});
    @(posedge clk); #4;
    check("redir_t5_pc", {16'h0, out_pc}, {16'h0, t2});
  endtask

  initial begin
    logic found;
    int   n_req;
    int   pops_before;
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", {31'h0, out_valid}, 32'h0);
    check("reset_pc", {16'h0, out_pc}, 32'h0);
    check("reset_instr", {16'h0, out_instr}, 32'h0);
    check("reset_req", {31'h0, mem_req}, 32'h0);

    // Streaming from reset, then redirect in the cycle that pops pc 4.
    release_and_first(1'b1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_pc == 16'h0004) found = 1'b1;
    end
    check("found_pc4", {31'h0, found}, 32'h1);
    redirect_and_check(16'h0040);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stream_no_gap", {31'h0, out_valid}, 32'h1);
    end

    // Wrap-around target.
    @(posedge clk); #1;
    redirect_and_check(16'hFFFF);

    // Back-to-back redirects: only the second target is delivered.
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    @(posedge clk); #1;
    redirect_pc    = 16'h0200;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    #3;
    check("b2b_t2_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #4;
    check("b2b_t3_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #4;
    check("b2b_t4_valid", {31'h0, out_valid}, 32'h1);
    check("b2b_t4_pc", {16'h0, out_pc}, 32'h0200);

    // Backpressure from reset: exactly three fetches fill the FIFO.
    @(posedge clk); #1;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    release_and_first(1'b0);
    n_req = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_req) begin
        check("stall_raddr", {16'h0, mem_raddr}, {16'h0, TB_RESET_PC + 16'(n_req)});
        n_req++;
      end
    end
    check("stall_req_count", n_req, 3);
    check("stall_req_low", {31'h0, mem_req}, 32'h0);
    check("stall_full_valid", {31'h0, out_valid}, 32'h1);
    check("stall_head_pc", {16'h0, out_pc}, {16'h0, TB_RESET_PC});
    @(posedge clk); #1;
    out_ready = 1'b1;
    pops_before = n_pops;
    repeat (12) @(posedge clk);
    check("stall_drain_pops", {31'h0, (n_pops - pops_before) >= 10}, 32'h1);

    // Asynchronous reset with buffered entries.
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("prefill_valid", {31'h0, out_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'h0, out_valid}, 32'h0);
    check("async_pc", {16'h0, out_pc}, 32'h0);
    check("async_instr", {16'h0, out_instr}, 32'h0);
    check("async_req", {31'h0, mem_req}, 32'h0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    release_and_first(1'b1);

    // Randomized traffic checked by the stream scoreboard.
    pops_before = n_pops;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFFD + 16'($urandom_range(0, 4));
      else redirect_pc = 16'($urandom());
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    repeat (8) @(posedge clk);
    check("random_liveness", {31'h0, (n_pops - pops_before) > 300}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
